// File: rtl/alu_pkg.sv
// Shared ALU definitions for the uCode datapath: opcode width and opcode encodings.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        NO_OP  = 4'd0,
        ADD_OP = 4'd1,
        SUB_OP = 4'd2,
        AND_OP = 4'd3,
        OR_OP  = 4'd4,
        XOR_OP = 4'd5,
        ROL_OP = 4'd6,
        ROR_OP = 4'd7,
        SHL_OP = 4'd8,
        SHR_OP = 4'd9,
        ASR_OP = 4'd10,
        NOT_OP = 4'd11
    } alu_op_e;

endpackage

// File: rtl/alu_lifo_if.sv
// Bus bundle for alu_lifo: stack push/pop/peek signals plus ALU operands and result.
interface alu_lifo_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 12
) ();

    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] i_data;
    logic             i_push;
    logic             i_pop;
    logic [WIDTH-1:0] o_s0;
    logic [WIDTH-1:0] o_s1;
    logic [DW-1:0]    o_depth;
    logic [OP_W-1:0]  i_op;
    logic [WIDTH-1:0] i_arg0;
    logic [WIDTH-1:0] i_arg1;
    logic [WIDTH-1:0] o_data;

    modport master (
        output i_data, i_push, i_pop, i_op, i_arg0, i_arg1,
        input  o_s0, o_s1, o_depth, o_data
    );

    modport slave (
        input  i_data, i_push, i_pop, i_op, i_arg0, i_arg1,
        output o_s0, o_s1, o_depth, o_data
    );

endinterface

// File: rtl/alu_lifo_lifo.sv
// Shift-register LIFO: cell[0] is TOS, cell[1] is NOS; saturating depth counter.
module lifo #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 12,
    localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_s0,
    output logic [WIDTH-1:0] o_s1,
    output logic [DW-1:0]    o_depth
);

    logic [WIDTH-1:0] r_cell [DEPTH];
    logic [DW-1:0]    r_depth;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_cell[k] <= '0;
            end
            r_depth <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    // Full push shifts the bottom cell out and keeps depth saturated.
                    r_cell[0] <= i_data;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_cell[k] <= r_cell[k-1];
                    end
                    if (r_depth != DW'(DEPTH)) begin
                        r_depth <= r_depth + DW'(1);
                    end
                end
                2'b01: begin
                    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
                        r_cell[k] <= r_cell[k+1];
                    end
                    r_cell[DEPTH-1] <= '0;
                    if (r_depth != '0) begin
                        r_depth <= r_depth - DW'(1);
                    end
                end
                2'b11: begin
                    // Replace TOS; an empty stack gains its first entry.
                    r_cell[0] <= i_data;
                    if (r_depth == '0) begin
                        r_depth <= DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_s0    = r_cell[0];
    assign o_s1    = r_cell[1];
    assign o_depth = r_depth;

endmodule

// File: rtl/alu_lifo.sv
// Datapath core: LIFO stack plus a registered single-cycle ALU sharing clock and reset.
module alu_lifo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 12
) (
    input logic       i_clk,
    input logic       i_rst_n,
    alu_lifo_if.slave bus
);

    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] r_result;

    lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (bus.i_data),
        .i_push  (bus.i_push),
        .i_pop   (bus.i_pop),
        .o_s0    (bus.o_s0),
        .o_s1    (bus.o_s1),
        .o_depth (bus.o_depth)
    );

    // Reserved opcodes fall through to the arg0 pass-through default.
    always_comb begin
        w_alu = bus.i_arg0;
        case (alu_op_e'(bus.i_op))
            ADD_OP:  w_alu = bus.i_arg0 + bus.i_arg1;
            SUB_OP:  w_alu = bus.i_arg0 - bus.i_arg1;
            AND_OP:  w_alu = bus.i_arg0 & bus.i_arg1;
            OR_OP:   w_alu = bus.i_arg0 | bus.i_arg1;
            XOR_OP:  w_alu = bus.i_arg0 ^ bus.i_arg1;
            ROL_OP:  w_alu = {bus.i_arg0[WIDTH-2:0], bus.i_arg0[WIDTH-1]};
            ROR_OP:  w_alu = {bus.i_arg0[0], bus.i_arg0[WIDTH-1:1]};
            SHL_OP:  w_alu = {bus.i_arg0[WIDTH-2:0], 1'b0};
            SHR_OP:  w_alu = {1'b0, bus.i_arg0[WIDTH-1:1]};
            ASR_OP:  w_alu = {bus.i_arg0[WIDTH-1], bus.i_arg0[WIDTH-1:1]};
            NOT_OP:  w_alu = ~bus.i_arg0;
            default: w_alu = bus.i_arg0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= '0;
        end else begin
            r_result <= w_alu;
        end
    end

    assign bus.o_data = r_result;

endmodule

// File: tb/tb_alu_lifo.sv
// Directed self-checking bench for alu_lifo: stack ops, boundaries, ALU sweep, async reset.
module tb_alu_lifo;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_lifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    alu_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        bus.i_push = 1'b0;
        bus.i_pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.i_data  = '0;
        bus.i_push  = 1'b0;
        bus.i_pop   = 1'b0;
        bus.i_op    = NO_OP;
        bus.i_arg0  = '0;
        bus.i_arg1  = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        bus.i_data = v;
        bus.i_push = 1'b1;
        step();
    endtask

    task automatic pop();
        bus.i_pop = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        bus.i_op   = NO_OP;
        bus.i_arg0 = 16'h4321;
        push(16'hABCD);
        push(16'h1234);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_s0 !== 16'h0000) begin errors++; $display("FAIL reset_s0 got=%h exp=0000", bus.o_s0); end
        checks++;
        if (bus.o_s1 !== 16'h0000) begin errors++; $display("FAIL reset_s1 got=%h exp=0000", bus.o_s1); end
        checks++;
        if (bus.o_depth !== DW'(0)) begin errors++; $display("FAIL reset_depth got=%0d exp=0", bus.o_depth); end
        checks++;
        if (bus.o_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus.o_data); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        checks++;
        if (bus.o_s0 !== 16'h3333 || bus.o_s1 !== 16'h2222 || bus.o_depth !== DW'(3)) begin
            errors++;
            $display("FAIL push3 got=%h/%h/%0d exp=3333/2222/3", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        pop();
        checks++;
        if (bus.o_s0 !== 16'h2222 || bus.o_s1 !== 16'h1111 || bus.o_depth !== DW'(2)) begin
            errors++;
            $display("FAIL pop1 got=%h/%h/%0d exp=2222/1111/2", bus.o_s0, bus.o_s1, bus.o_depth);
        end
    endtask

    task automatic test_replace();
        do_reset();
        push(16'h0009);
        push(16'h0005);
        bus.i_op   = ADD_OP;
        bus.i_arg0 = bus.o_s0;
        bus.i_arg1 = 16'h0001;
        step();
        checks++;
        if (bus.o_data !== 16'h0006) begin errors++; $display("FAIL replace_alu got=%h exp=0006", bus.o_data); end
        bus.i_data = bus.o_data;
        bus.i_push = 1'b1;
        bus.i_pop  = 1'b1;
        step();
        checks++;
        if (bus.o_s0 !== 16'h0006 || bus.o_s1 !== 16'h0009 || bus.o_depth !== DW'(2)) begin
            errors++;
            $display("FAIL replace_tos got=%h/%h/%0d exp=0006/0009/2", bus.o_s0, bus.o_s1, bus.o_depth);
        end
    endtask

    task automatic test_swap();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        do_reset();
        push(16'hAAAA);
        push(16'hBBBB);
        a = bus.o_s0;
        b = bus.o_s1;
        pop();
        bus.i_data = a;
        bus.i_push = 1'b1;
        bus.i_pop  = 1'b1;
        step();
        push(b);
        checks++;
        if (bus.o_s0 !== 16'hAAAA || bus.o_s1 !== 16'hBBBB || bus.o_depth !== DW'(2)) begin
            errors++;
            $display("FAIL swap got=%h/%h/%0d exp=aaaa/bbbb/2", bus.o_s0, bus.o_s1, bus.o_depth);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 13; i++) push(WIDTH'(i));
        checks++;
        if (bus.o_s0 !== 16'd13 || bus.o_s1 !== 16'd12 || bus.o_depth !== DW'(12)) begin
            errors++;
            $display("FAIL full got=%0d/%0d/%0d exp=13/12/12", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        for (int i = 0; i < 11; i++) pop();
        checks++;
        if (bus.o_s0 !== 16'd2 || bus.o_s1 !== 16'd0 || bus.o_depth !== DW'(1)) begin
            errors++;
            $display("FAIL full_bottom got=%0d/%0d/%0d exp=2/0/1", bus.o_s0, bus.o_s1, bus.o_depth);
        end
        pop();
        checks++;
        if (bus.o_s0 !== 16'd0 || bus.o_depth !== DW'(0)) begin
            errors++;
            $display("FAIL full_lost got=%0d/%0d exp=0/0", bus.o_s0, bus.o_depth);
        end
    endtask

    task automatic test_empty();
        do_reset();
        pop();
        checks++;
        if (bus.o_s0 !== 16'h0000 || bus.o_depth !== DW'(0)) begin
            errors++;
            $display("FAIL pop_empty got=%h/%0d exp=0000/0", bus.o_s0, bus.o_depth);
        end
        bus.i_data = 16'h0077;
        bus.i_push = 1'b1;
        bus.i_pop  = 1'b1;
        step();
        checks++;
        if (bus.o_s0 !== 16'h0077 || bus.o_s1 !== 16'h0000 || bus.o_depth !== DW'(1)) begin
            errors++;
            $display("FAIL replace_empty got=%h/%h/%0d exp=0077/0000/1", bus.o_s0, bus.o_s1, bus.o_depth);
        end
    endtask

    task automatic test_alu();
        logic [3:0]       ops [14];
        logic [WIDTH-1:0] exps [14];
        ops  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd13, 4'd15};
        exps = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003, 16'h8002, 16'h0003, 16'hC000,
                 16'h0002, 16'h4000, 16'hC000, 16'h7FFE, 16'h8001, 16'h8001, 16'h8001};
        do_reset();
        bus.i_arg0 = 16'h8001;
        bus.i_arg1 = 16'h0003;
        for (int i = 0; i < 14; i++) begin
            bus.i_op = ops[i];
            step();
            checks++;
            if (bus.o_data !== exps[i]) begin
                errors++;
                $display("FAIL alu_op%0d got=%h exp=%h", ops[i], bus.o_data, exps[i]);
            end
        end
        bus.i_op   = ADD_OP;
        bus.i_arg0 = 16'hFFFF;
        bus.i_arg1 = 16'h0001;
        step();
        checks++;
        if (bus.o_data !== 16'h0000) begin errors++; $display("FAIL alu_wrap got=%h exp=0000", bus.o_data); end
        bus.i_op   = ASR_OP;
        bus.i_arg0 = 16'h4002;
        step();
        checks++;
        if (bus.o_data !== 16'h2001) begin errors++; $display("FAIL alu_asr_pos got=%h exp=2001", bus.o_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.i_op   = NO_OP;
        bus.i_arg0 = 16'h5A5A;
        push(16'h0101);
        push(16'h0202);
        push(16'h0303);
        checks++;
        if (bus.o_depth !== DW'(3) || bus.o_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL async_pre got=%0d/%h exp=3/5a5a", bus.o_depth, bus.o_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_s0 !== '0 || bus.o_s1 !== '0 || bus.o_data !== '0 || bus.o_depth !== '0) begin
            errors++;
            $display("FAIL async_reset got=%h/%h/%h/%0d exp=0/0/0/0", bus.o_s0, bus.o_s1, bus.o_data, bus.o_depth);
        end
        #1;
        rst_n = 1'b1;
        push(16'h0404);
        checks++;
        if (bus.o_s0 !== 16'h0404 || bus.o_depth !== DW'(1)) begin
            errors++;
            $display("FAIL async_resume got=%h/%0d exp=0404/1", bus.o_s0, bus.o_depth);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_push_pop();
        test_replace();
        test_swap();
        test_full();
        test_empty();
        test_alu();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_lifo.md
Name: alu_lifo

Overview:
- Datapath core for the uCode CPU: a parameterised LIFO stack plus a registered ALU, sharing one clock and reset.
- The CPU instantiates one alu_lifo as its data stack (using the ALU) and a second one as its return stack (ALU port unused).
- The stack exposes its top two cells combinationally from registers; the ALU result is registered with 1-cycle latency.

Parameters:
- WIDTH, 16, bits per cell and per ALU operand/result.
- DEPTH, 12, number of stack cells (min 2).

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_data  in  WIDTH  value written by a push.
- i_push  in  1  push request.
- i_pop  in  1  pop request.
- o_s0  out  WIDTH  top of stack (TOS).
- o_s1  out  WIDTH  next on stack (NOS).
- o_depth  out  $clog2(DEPTH+1)  occupied cell count.
- i_op  in  4  ALU opcode.
- i_arg0  in  WIDTH  ALU operand 0.
- i_arg1  in  WIDTH  ALU operand 1.
- o_data  out  WIDTH  registered ALU result.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all stack cells=0, o_depth=0, o_data=0. Asserting reset mid-operation clears everything immediately. Operations resume on the first rising edge after deassertion.
- Stack is a shift-register array; cell[0]=o_s0, cell[1]=o_s1.
- Push only: cell[0]<=i_data, cell[k]<=cell[k-1]; depth+1 (saturates at DEPTH). Push when full discards the bottom cell, no error.
- Pop only: cell[k]<=cell[k+1], bottom cell<=0; depth-1 (saturates at 0). Pop when empty leaves all cells 0, depth stays 0.
- Push and pop together: replace TOS. cell[0]<=i_data, others unchanged, depth unchanged. If empty, depth becomes 1.
- Neither asserted: hold.
- Outputs reflect the new state the cycle after the request edge.
- ALU: o_data <= f(i_op, i_arg0, i_arg1) every clock, so the result is available 1 cycle after the operands are presented.
- Arithmetic is modulo 2^WIDTH; no carry or flags.
- Opcodes:
  - 0 NO_OP: arg0 (pass-through).
  - 1 ADD_OP: arg0+arg1.
  - 2 SUB_OP: arg0-arg1.
  - 3 AND_OP: arg0&arg1.
  - 4 OR_OP: arg0|arg1.
  - 5 XOR_OP: arg0^arg1.
  - 6 ROL_OP: {arg0[W-2:0],arg0[W-1]}.
  - 7 ROR_OP: {arg0[0],arg0[W-1:1]}.
  - 8 SHL_OP: arg0<<1.
  - 9 SHR_OP: arg0>>1 (logical).
  - 10 ASR_OP: arithmetic right shift by 1.
  - 11 NOT_OP: ~arg0.
  - 12-15 reserved: output arg0.
- Stack and ALU are independent; the same-cycle use pattern "op on o_s0, then push+pop o_data" must work. The ALU samples pre-edge o_s0, and the result is written back the following cycle.

Decomposition:
- Shared package alu_pkg: the 4-bit opcode constants NO_OP..NOT_OP and the opcode width.
- One sub-module, lifo: the stack array, depth counter and push/pop logic, with parameters WIDTH and DEPTH.
- ALU logic lives inline in alu_lifo.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 -> o_s0=0x3333, o_s1=0x2222, o_depth=3; pop -> 0x2222/0x1111, depth 2.
- Replace: with TOS=0x0005, apply op ADD_OP, arg0=o_s0, arg1=1; next cycle push+pop i_data=o_data -> o_s0=0x0006, o_s1 unchanged, depth unchanged.
- Swap sequence (pop then push of saved values) on stack 0xAAAA,0xBBBB -> o_s0=0xAAAA, o_s1=0xBBBB.
- Boundaries:
  - DEPTH+1 pushes of values 1..13 -> depth=12, o_s0=13, value 1 lost.
  - Pop on empty -> o_s0=0, depth=0.
  - Push+pop on empty -> depth=1.
- ALU sweep, arg0=0x8001, arg1=0x0003:
  - ADD 0x8004, SUB 0x7FFE, AND 0x0001, OR 0x8003, XOR 0x8002.
  - ROL 0x0003, ROR 0xC000, SHL 0x0002, SHR 0x4000, ASR 0xC000, NOT 0x7FFE, NO_OP 0x8001, op 13 -> 0x8001.
  - ADD 0xFFFF+1 -> 0x0000.
- Async reset mid-stream: pull i_rst_n low between clock edges with depth 3 -> o_s0, o_s1, o_data, o_depth all 0 before the next edge.
